// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
//
// Debug observer that sits beside the UART frame receiver and the
// register file. It does two jobs:
//   * Live outputs: shows the latest captured frame and register value
//     while debug is enabled. Both outputs read as zero when debug is off.
//   * Trace FIFO: keeps the last DEPTH received frames. Software reads
//     them back with a single-cycle pop handshake.
// The FIFO has two capture modes for when it is full:
//   * wrap: overwrite the oldest entry.
//   * stop: drop the new frame.
// Every lost or overwritten frame increments a saturating counter.
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   debug_i          debug enable (0 freezes trace capture, zeroes live outputs)
//   clr_i            synchronous clear of trace FIFO and overflow counter
//   mode_i           0 = wrap (overwrite oldest), 1 = stop (drop when full)
//   frame_valid_i    frame strobe
//   frame_i          received frame
//   data_out_valid_i register-value strobe
//   data_out_i       register value
//   rd_en_i          pop request
//   debug_frame_o    last captured frame
//   debug_reg_o      last captured register value
//   rd_valid_o       rd_frame_o valid this cycle (1-cycle pulse)
//   rd_frame_o       popped entry
//   rd_underflow_o   pop attempted on an empty FIFO (1-cycle pulse)
//   count_o          occupied entries, 0..DEPTH
//   overflow_cnt_o   frames lost or overwritten, saturating

module debug_trace_buffer #(
    parameter int FRAME_W = 9,
    parameter int REG_W   = 4,
    parameter int DEPTH   = 8,
    parameter int OVF_W   = 8,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               debug_i,
    input  logic               clr_i,
    input  logic               mode_i,
    input  logic               frame_valid_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               data_out_valid_i,
    input  logic [REG_W-1:0]   data_out_i,
    input  logic               rd_en_i,
    output logic [FRAME_W-1:0] debug_frame_o,
    output logic [REG_W-1:0]   debug_reg_o,
    output logic               rd_valid_o,
    output logic [FRAME_W-1:0] rd_frame_o,
    output logic               rd_underflow_o,
    output logic [CW-1:0]      count_o,
    output logic [OVF_W-1:0]   overflow_cnt_o
);

    logic [FRAME_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_underflow_q, rd_underflow_d;
    logic [FRAME_W-1:0] rd_frame_q, rd_frame_d;
    logic [FRAME_W-1:0] dbg_frame_q, dbg_frame_d;
    logic [REG_W-1:0]   dbg_reg_q, dbg_reg_d;

    logic empty, full;
    logic wr_req, rd_req;
    logic do_wr, do_rd, overwrite, inc, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Clear has priority: a write or read in the same cycle is ignored.
    assign wr_req = debug_i && frame_valid_i && !clr_i;
    assign rd_req = rd_en_i && !clr_i;

    // Occupancy is judged before either operation.
    // When the FIFO is full and a pop happens in the same cycle, the pop
    // frees a slot, so the write is accepted in either mode. The written
    // slot (wr_ptr) is the same slot as rd_ptr. The pop still reads the
    // old contents because both happen on the same clock edge.
    assign do_rd     = rd_req && !empty;
    assign overwrite = wr_req && full && !do_rd && !mode_i;
    assign drop      = wr_req && full && !do_rd && mode_i;
    assign do_wr     = wr_req && !drop;
    assign inc       = do_wr && !overwrite;

    // Next-state for pointers, occupancy, the overflow counter and the
    // pop outputs.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        rd_valid_d     = 1'b0;
        rd_underflow_d = 1'b0;
        rd_frame_d     = rd_frame_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd || overwrite) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_valid_d = 1'b1;
                rd_frame_d = mem_q[rd_ptr_q];
            end
            rd_underflow_d = rd_req && empty;
            if (inc && !do_rd) begin
                count_d = count_q + 1'b1;
            end else if (do_rd && !inc) begin
                count_d = count_q - 1'b1;
            end
            if ((overwrite || drop) && (ovf_q != '1)) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    // Live registers: they follow the strobes while debug is on. They read
    // as zero while debug is off. Clear does not affect them.
    always_comb begin
        dbg_frame_d = '0;
        dbg_reg_d   = '0;
        if (debug_i) begin
            dbg_frame_d = frame_valid_i    ? frame_i    : dbg_frame_q;
            dbg_reg_d   = data_out_valid_i ? data_out_i : dbg_reg_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ovf_q          <= '0;
            rd_valid_q     <= 1'b0;
            rd_underflow_q <= 1'b0;
            rd_frame_q     <= '0;
            dbg_frame_q    <= '0;
            dbg_reg_q      <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            rd_valid_q     <= rd_valid_d;
            rd_underflow_q <= rd_underflow_d;
            rd_frame_q     <= rd_frame_d;
            dbg_frame_q    <= dbg_frame_d;
            dbg_reg_q      <= dbg_reg_d;
        end
    end

    // Trace storage has no reset. Valid contents are tracked only by the
    // pointers and count, so stale data is never popped.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= frame_i;
        end
    end

    assign debug_frame_o  = dbg_frame_q;
    assign debug_reg_o    = dbg_reg_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_frame_o     = rd_frame_q;
    assign rd_underflow_o = rd_underflow_q;
    assign count_o        = count_q;
    assign overflow_cnt_o = ovf_q;

endmodule
